register_file_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard and optional write-to-read bypass. It is the next-generation architectural register file for the pipelined core. Decode reads operands through NRD read ports and marks destinations busy at issue. NWR writeback ports, for example ALU and load, retire results and clear busy bits. Register 0 is hardwired to zero. The stack pointer is reset to a configurable value.

---
 rtl/register_file_mp.sv | 94 +++++++++
 tb/tb_register_file_mp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file with per-register busy scoreboard and optional same-cycle write bypass.
// Reads are combinational and writes commit at the rising edge; the block has no backpressure and never stalls.
module register_file_mp #(
  parameter int          DWIDTH  = 32,
  parameter int          NREGS   = 32,
  parameter int          NRD     = 2,
  parameter int          NWR     = 2,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h0110_0000,
  parameter int          BYPASS  = 1,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rs_addr_i,
  output logic [NRD*DWIDTH-1:0] rs_data_o,
  output logic [NRD-1:0]        rs_busy_o,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*AW-1:0]     wr_addr_i,
  input  logic [NWR*DWIDTH-1:0] wr_data_i,
  input  logic                  iss_en_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic                  flush_i,
  output logic [NREGS-1:0]      busy_o
);

  localparam logic [DWIDTH-1:0] SP_RST = DWIDTH'(SP_INIT);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  wr_hit;

  // Ascending port order lets the highest-numbered port win a same-address collision.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) regs_d[r] = regs_q[r];
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && wr_addr_i[j*AW +: AW] != '0) begin
        wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
        regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_i)                                busy_d[r] = 1'b0;
      else if (iss_en_i && iss_rd_i == AW'(r))    busy_d[r] = 1'b1;
      else if (wr_hit[r])                         busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= (r == SP_IDX) ? SP_RST : '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [AW-1:0]     ra;
    logic [DWIDTH-1:0] rdat;
    logic              rhit;
    rs_data_o = '0;
    rs_busy_o = '0;
    ra        = '0;
    rdat      = '0;
    rhit      = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra   = rs_addr_i[k*AW +: AW];
      rdat = regs_q[ra];
      rhit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == ra && ra != '0) begin
            rdat = wr_data_i[j*DWIDTH +: DWIDTH];
            rhit = 1'b1;
          end
        end
      end
      rs_data_o[k*DWIDTH +: DWIDTH] = rdat;
      rs_busy_o[k]                  = busy_q[ra] & ~rhit;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp: bypass and non-bypass instances share stimulus
// and are compared against an array-based reference model of the register file rules.
module tb_register_file_mp;

  localparam int DW = 32, NR = 32, NRD = 2, NWR = 2, AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rs_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_rd;
  logic              flush;

  logic [NRD*DW-1:0] rd_b, rd_n;
  logic [NRD-1:0]    rbusy_b, rbusy_n;
  logic [NR-1:0]     busy_b, busy_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(rd_b), .rs_busy_o(rbusy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_rd_i(iss_rd), .flush_i(flush), .busy_o(busy_b));

  register_file_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(rd_n), .rs_busy_o(rbusy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_rd_i(iss_rd), .flush_i(flush), .busy_o(busy_n));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = (r == 2) ? 32'h0110_0000 : 32'h0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    rs_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  // Reference read: stored value, optionally overridden by the last matching enabled writer.
  task automatic exp_read(input int k, input bit byp, output logic [DW-1:0] d, output bit b);
    int  a;
    bit  hit;
    a   = int'(rs_addr[k*AW +: AW]);
    d   = m_reg[a];
    hit = 1'b0;
    if (byp && a != 0)
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
          d = wr_data[j*DW +: DW];
          hit = 1'b1;
        end
    b = m_busy[a] && !hit;
    if (a == 0) begin d = '0; b = 1'b0; end
  endtask

  task automatic model_commit();
    bit written [NR];
    for (int r = 0; r < NR; r++) written[r] = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      int a;
      a = int'(wr_addr[j*AW +: AW]);
      if (wr_en[j] && a != 0) begin
        m_reg[a] = wr_data[j*DW +: DW];
        written[a] = 1'b1;
      end
    end
    for (int r = 1; r < NR; r++) begin
      if (flush)                             m_busy[r] = 1'b0;
      else if (iss_en && int'(iss_rd) == r)  m_busy[r] = 1'b1;
      else if (written[r])                   m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] d;
    bit            b;
    for (int k = 0; k < NRD; k++) begin
      exp_read(k, 1'b1, d, b);
      chk($sformatf("byp_data%0d", k), rd_b[k*DW +: DW], d);
      chk($sformatf("byp_busy%0d", k), rbusy_b[k], b);
      exp_read(k, 1'b0, d, b);
      chk($sformatf("nob_data%0d", k), rd_n[k*DW +: DW], d);
      chk($sformatf("nob_busy%0d", k), rbusy_n[k], b);
    end
    chk("busy_o_b", busy_b, model_busy_vec());
    chk("busy_o_n", busy_n, model_busy_vec());
  endtask

  // Inputs are already driven; check combinational outputs, then clock and update the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a);
      #1;
      chk($sformatf("rst_rd%0d", a), rd_n[DW-1:0], (a == 2) ? 32'h0110_0000 : 32'h0);
    end
    chk("rst_busy", busy_b, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while a write is pending must discard it.
    idle();
    set_wr(0, 5, 32'hCAFE_F00D);
    iss_en = 1'b1; iss_rd = 5'd5;
    #1 rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    idle(); set_rd(0, 5);
    #1;
    chk("rst_midwr_x5", rd_n[DW-1:0], 32'h0);
    chk("rst_midwr_busy", busy_n, '0);
    @(posedge clk); #1;

    idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5);
    #1;
    chk("x5_bypass", rd_b[DW-1:0], 32'hDEAD_BEEF);
    chk("x5_nobypass_old", rd_n[DW-1:0], 32'h0);
    cycle();
    idle(); set_rd(0, 5);
    #1;
    chk("x5_nobypass_next", rd_n[DW-1:0], 32'hDEAD_BEEF);
    cycle();

    idle(); set_wr(0, 0, 32'h1234); set_rd(0, 0); set_rd(1, 0);
    cycle();
    idle(); set_rd(0, 0); set_rd(1, 0);
    #1;
    chk("x0_zero", rd_b[DW +: DW], 32'h0);
    cycle();

    idle(); set_wr(0, 7, 32'hAAAA); set_wr(1, 7, 32'h5555); set_rd(1, 7);
    #1;
    chk("x7_coll_bypass", rd_b[DW +: DW], 32'h5555);
    cycle();
    idle(); set_rd(0, 7);
    #1;
    chk("x7_coll_stored", rd_n[DW-1:0], 32'h5555);
    cycle();

    idle(); iss_en = 1'b1; iss_rd = 5'd9;
    cycle();
    idle(); set_rd(0, 9); set_wr(1, 9, 32'h99);
    #1;
    chk("x9_busy_set", busy_b[9], 1'b1);
    chk("x9_rsbusy_byp", rbusy_b[0], 1'b0);
    chk("x9_rsbusy_nob", rbusy_n[0], 1'b1);
    cycle();
    chk("x9_busy_clr", busy_b[9], 1'b0);

    idle(); iss_en = 1'b1; iss_rd = 5'd4;
    cycle();
    idle(); iss_en = 1'b1; iss_rd = 5'd4; set_wr(0, 4, 32'h4444);
    cycle();
    idle(); set_rd(0, 4);
    #1;
    chk("x4_still_busy", busy_b[4], 1'b1);
    chk("x4_data", rd_n[DW-1:0], 32'h4444);
    cycle();

    for (int i = 0; i < 3; i++) begin
      idle(); iss_en = 1'b1; iss_rd = (i == 0) ? 5'd3 : (i == 1) ? 5'd6 : 5'd8;
      cycle();
    end
    idle(); flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd10; set_wr(1, 3, 32'h77);
    cycle();
    idle(); set_rd(0, 3);
    #1;
    chk("flush_busy", busy_b, '0);
    chk("flush_x3", rd_n[DW-1:0], 32'h77);
    cycle();

    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int k = 0; k < NRD; k++) set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, 7), $urandom());
      iss_en = ($urandom_range(0, 2) == 0);
      iss_rd = AW'($urandom_range(0, 7));
      flush  = ($urandom_range(0, 40) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
